// File: rtl/cb_pkg.sv
// Shared types and geometry helpers for the parameterised connection box.
// Loader state encoding and the derived config-word sizes live here.
package cb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_TOKEN = 3'd1,
    ST_SHIFT      = 3'd2,
    ST_COMMIT     = 3'd3,
    ST_DONE       = 3'd4
  } cb_state_e;

  // A single-track box still needs one index bit so field slices stay legal.
  function automatic int calc_selw(input int num_tracks);
    return (num_tracks > 1) ? $clog2(num_tracks) : 1;
  endfunction

  function automatic int calc_cfg_bits(input int num_tracks, input int num_in,
                                       input int num_out);
    return num_in * (calc_selw(num_tracks) + 1) + num_out * num_tracks;
  endfunction

endpackage

// File: rtl/cb_cfg_loader.sv
// Serial configuration loader: program-token handshake, shadow shift register
// and a one-cycle commit strobe toward the active register in the top level.
//
//   state          | meaning
//   ST_IDLE        | not loading; passes the chain token through in bypass
//   ST_WAIT_TOKEN  | selected for this pass, waiting for upstream to finish
//   ST_SHIFT       | shifting bit_in into the shadow, one bit per cycle
//   ST_COMMIT      | full word held; commit strobe fires unless aborted
//   ST_DONE        | loaded; token to downstream held high until prgm_b rises
module cb_cfg_loader
  import cb_pkg::*;
#(
  parameter int CFG_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prgm_b,
  input  logic                cb_prgm_b,
  input  logic                cb_prgm_b_in,
  input  logic                bit_in,
  output logic [CFG_BITS-1:0] shadow,
  output logic                commit,
  output logic                cb_prgm_b_out
);

  localparam int CNTW = $clog2(CFG_BITS + 1);

  cb_state_e           state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic                tok_q, tok_d;
  logic [CFG_BITS-1:0] shifted;
  logic                last_bit;

  assign shifted  = {shadow_q[CFG_BITS-2:0], bit_in};
  assign last_bit = (cnt_q == CNTW'(CFG_BITS - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tok_d    = tok_q;
    commit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!prgm_b && cb_prgm_b) begin
          state_d = ST_WAIT_TOKEN;
        end else if (!prgm_b) begin
          tok_d = cb_prgm_b_in;
        end else begin
          tok_d = 1'b0;
        end
      end
      ST_WAIT_TOKEN: begin
        if (prgm_b) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (cb_prgm_b_in) begin
          shadow_d = shifted;
          cnt_d    = CNTW'(1);
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (prgm_b) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          shadow_d = '0;
        end else begin
          shadow_d = shifted;
          cnt_d    = cnt_q + CNTW'(1);
          if (last_bit) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        if (prgm_b) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          shadow_d = '0;
        end else begin
          commit  = 1'b1;
          tok_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (prgm_b) begin
          state_d = ST_IDLE;
          tok_d   = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        shadow_d = '0;
        tok_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      tok_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      tok_q    <= tok_d;
    end
  end

  assign shadow        = shadow_q;
  assign cb_prgm_b_out = tok_q;

endmodule

// File: rtl/cb_param.sv
// Connection box: double-buffered configuration (shadow in the loader, active
// here) steering tracks onto logic inputs and logic outputs onto tracks.
module cb_param
  import cb_pkg::*;
#(
  parameter int NUM_TRACKS = 8,
  parameter int NUM_IN     = 4,
  parameter int NUM_OUT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prgm_b,
  input  logic                  cb_prgm_b,
  input  logic                  cb_prgm_b_in,
  output logic                  cb_prgm_b_out,
  input  logic                  bit_in_CB,
  output logic                  bit_out_CB,
  input  logic [NUM_TRACKS-1:0] track_in,
  output logic [NUM_IN-1:0]     x,
  input  logic [NUM_OUT-1:0]    q,
  output logic [NUM_TRACKS-1:0] track_out,
  output logic [NUM_TRACKS-1:0] track_oe,
  output logic                  cfg_valid,
  output logic                  cfg_err
);

  localparam int SELW     = calc_selw(NUM_TRACKS);
  localparam int CFG_BITS = calc_cfg_bits(NUM_TRACKS, NUM_IN, NUM_OUT);
  localparam int Q_BASE   = NUM_IN * (SELW + 1);

  logic [CFG_BITS-1:0] shadow;
  logic                commit;

  logic [CFG_BITS-1:0] active_q, active_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                cfg_err_q, cfg_err_d;
  logic                shadow_err;

  logic [NUM_TRACKS-1:0] drv_seen, drv_multi, drv_val, mask_j;

  cb_cfg_loader #(
    .CFG_BITS (CFG_BITS)
  ) u_loader (
    .clk           (clk),
    .reset         (reset),
    .prgm_b        (prgm_b),
    .cb_prgm_b     (cb_prgm_b),
    .cb_prgm_b_in  (cb_prgm_b_in),
    .bit_in        (bit_in_CB),
    .shadow        (shadow),
    .commit        (commit),
    .cb_prgm_b_out (cb_prgm_b_out)
  );

  assign bit_out_CB = shadow[CFG_BITS-1];

  function automatic logic field_en(input logic [CFG_BITS-1:0] cfg, input int i);
    return cfg[i*(SELW+1) + SELW];
  endfunction

  function automatic logic [SELW-1:0] field_idx(input logic [CFG_BITS-1:0] cfg,
                                                input int i);
    return cfg[i*(SELW+1) +: SELW];
  endfunction

  function automatic logic [NUM_TRACKS-1:0] q_mask(input logic [CFG_BITS-1:0] cfg,
                                                   input int j);
    return cfg[Q_BASE + j*NUM_TRACKS +: NUM_TRACKS];
  endfunction

  // Out-of-range index (only reachable when NUM_TRACKS is not a power of two)
  // or a track claimed by more than one output.
  function automatic logic cfg_has_error(input logic [CFG_BITS-1:0] cfg);
    logic                  err;
    logic [NUM_TRACKS-1:0] seen;
    logic [NUM_TRACKS-1:0] m;
    err  = 1'b0;
    seen = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (field_en(cfg, i) && (int'(field_idx(cfg, i)) >= NUM_TRACKS)) begin
        err = 1'b1;
      end
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      m = q_mask(cfg, j);
      if ((seen & m) != '0) begin
        err = 1'b1;
      end
      seen = seen | m;
    end
    return err;
  endfunction

  assign shadow_err = cfg_has_error(shadow);

  always_comb begin
    active_d    = active_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;
    if (commit) begin
      active_d    = shadow;
      cfg_valid_d = 1'b1;
      cfg_err_d   = shadow_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q    <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      active_q    <= active_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    x = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        if (field_en(active_q, i) && (int'(field_idx(active_q, i)) == t)) begin
          x[i] = track_in[t];
        end
      end
    end
  end

  // First driver of each track wins the value; any second driver marks the
  // track as contended so it is left undriven.
  always_comb begin
    drv_seen  = '0;
    drv_multi = '0;
    drv_val   = '0;
    mask_j    = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      mask_j    = q_mask(active_q, j);
      drv_multi = drv_multi | (drv_seen & mask_j);
      drv_val   = drv_val | (mask_j & ~drv_seen & {NUM_TRACKS{q[j]}});
      drv_seen  = drv_seen | mask_j;
    end
  end

  assign track_oe  = drv_seen & ~drv_multi;
  assign track_out = drv_val & track_oe;

endmodule

// File: doc/cb_param.md
CB_PARAM -- requirements
Module: cb_param

Interface
REQ-001 SHALL have parameter NUM_TRACKS, default 8, meaning routing tracks adjacent to the box.
REQ-002 SHALL have parameter NUM_IN, default 4, meaning logic-input pins (x) fed from tracks.
REQ-003 SHALL have parameter NUM_OUT, default 2, meaning logic-output pins (q) driven onto tracks.
REQ-004 SHALL derive SELW = clog2(NUM_TRACKS) and CFG_BITS = NUM_IN*(SELW+1) + NUM_OUT*NUM_TRACKS (32 at defaults).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 prgm_b  in  1  global program, active low; low means programming mode.
REQ-008 cb_prgm_b  in  1  local select; high means this box takes part in the current program pass.
REQ-009 cb_prgm_b_in  in  1  daisy-chain token from upstream; high means upstream loading is finished.
REQ-010 cb_prgm_b_out  out  1  daisy-chain token to downstream.
REQ-011 bit_in_CB  in  1  serial configuration data, broadcast to all boxes in the chain.
REQ-012 bit_out_CB  out  1  readback; MSB of the shadow register.
REQ-013 track_in  in  NUM_TRACKS  track values seen by the box.
REQ-014 x  out  NUM_IN  pin values selected from the tracks.
REQ-015 q  in  NUM_OUT  logic outputs to be placed onto the tracks.
REQ-016 track_out / track_oe  out  NUM_TRACKS each  drive value and drive enable per track.
REQ-017 cfg_valid / cfg_err  out  1 each  active config is loaded / sticky configuration error.

Function
REQ-018 Config word layout (LSB first): x[i] field = bits [i*(SELW+1) +: SELW+1]; field top bit = enable, lower SELW bits = track index; q[j] mask = bits [NUM_IN*(SELW+1) + j*NUM_TRACKS +: NUM_TRACKS].
REQ-019 Loader FSM states: IDLE, WAIT_TOKEN, SHIFT, COMMIT, DONE.
REQ-020 IDLE->WAIT_TOKEN when prgm_b=0 and cb_prgm_b=1; WAIT_TOKEN->SHIFT on the first cycle cb_prgm_b_in=1, and that cycle already shifts a bit.
REQ-021 In SHIFT, each cycle: shadow <= {shadow[CFG_BITS-2:0], bit_in_CB} and the bit counter increments; after CFG_BITS bits -> COMMIT. The first bit received ends at the MSB.
REQ-022 COMMIT lasts one cycle; at its closing edge active <= shadow, cfg_valid <= 1, and the state goes to DONE.
REQ-023 DONE holds cb_prgm_b_out=1 (registered) until prgm_b=1, then returns to IDLE with cb_prgm_b_out <= 0.
REQ-024 If prgm_b=0 and cb_prgm_b=0 (bypass), cb_prgm_b_out SHALL equal cb_prgm_b_in delayed by one cycle; there is no shifting.
REQ-025 Abort: prgm_b=1 in WAIT_TOKEN, SHIFT or COMMIT-pending returns the FSM to IDLE, discards the shadow, clears the counter, leaves active, cfg_valid and cb_prgm_b_out unchanged.
REQ-026 Active config stays in force throughout any reprogramming (double buffered, glitch free).
REQ-027 x[i] = enable ? track_in[index] : 0, combinational from track_in and active.
REQ-028 An index >= NUM_TRACKS (non-power-of-2 only) SHALL give x[i]=0 and set cfg_err on commit.
REQ-029 track_oe[t] = 1 iff exactly one q mask bit for t is set; track_out[t] = the q value of that driver, else 0.
REQ-030 Two or more drivers on a track SHALL give track_oe[t]=0 and set cfg_err on commit.
REQ-031 cfg_err is cleared only by reset or by a clean COMMIT.

Reset
REQ-032 On reset=1 at a clock edge: FSM=IDLE, counter=0, shadow=0, active=0, cb_prgm_b_out=0, cfg_valid=0, cfg_err=0. Hence x=0, track_oe=0 and track_out=0.
REQ-033 Reset SHALL take priority over every other event, including mid-SHIFT and COMMIT.

Structure
REQ-034 Package cb_pkg SHALL hold the FSM state enum and the CFG_BITS/SELW helper functions.
REQ-035 The FSM, counter and shadow register SHALL sit in the sub-module cb_cfg_loader. The top level holds the active register and the routing logic.

Verification
REQ-036 Reset: assert reset 2 cycles with random inputs -> all outputs 0 and cfg_valid=0.
REQ-037 Program, defaults: x[0] field=4'b1101, q[1] mask=8'h80, rest 0, 32 shift cycles -> COMMIT on cycle 33 and cb_prgm_b_out=1 from cycle 34. Then x[0] follows track_in[5], track_oe=8'h80, track_out[7]=q[1].
REQ-038 Abort: prgm_b high after 10 bits -> active config and x unchanged, cb_prgm_b_out=0, FSM back in IDLE.
REQ-039 Bypass: cb_prgm_b=0, toggle cb_prgm_b_in -> cb_prgm_b_out follows it 1 cycle later and the shadow is unchanged.
REQ-040 Conflict: q[0] and q[1] masks both 8'h04 -> track_oe[2]=0 and cfg_err=1. Reprogramming clean -> cfg_err=0.
REQ-041 NUM_TRACKS=6: x[1] index 7, enable 1 -> x[1]=0 and cfg_err=1. Reset at shift bit 20 -> all outputs 0 the next cycle.
